// File: rtl/axis_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats into one wide word; tlast forces early emit with lane tkeep.
// One-cycle latency from completing beat to output; s_axis_tready drops while the output word is stalled.
module axis_upsizer #(
  parameter int IN_WIDTH  = 32,
  parameter int RATIO     = 2,
  parameter int OUT_WIDTH = IN_WIDTH * RATIO,
  parameter int CNT_WIDTH = $clog2(RATIO)
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 s_axis_tvalid,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic                 m_axis_tvalid,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic [RATIO-1:0]     m_axis_tkeep,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready
);

  localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(RATIO - 1);

  logic [OUT_WIDTH-1:0] acc_dat;
  logic [RATIO-1:0]     acc_keep;
  logic [CNT_WIDTH-1:0] lane;

  logic                 s_acc;
  logic                 m_acc;
  logic                 complete;
  logic [OUT_WIDTH-1:0] beat_word;
  logic [RATIO-1:0]     beat_keep;

  assign s_axis_tready = !areset && (!m_axis_tvalid || m_axis_tready);
  assign s_acc         = s_axis_tvalid && s_axis_tready;
  assign m_acc         = m_axis_tvalid && m_axis_tready;
  assign complete      = (lane == LAST_LANE) || s_axis_tlast;

  // Current beat positioned in its lane; all other lanes zero so OR-merging keeps unused lanes clear.
  always_comb begin
    beat_word = '0;
    beat_keep = '0;
    beat_word[lane*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
    beat_keep[lane] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      acc_dat       <= '0;
      acc_keep      <= '0;
      lane          <= '0;
    end else begin
      if (m_acc) begin
        m_axis_tvalid <= 1'b0;
      end
      if (s_acc) begin
        if (complete) begin
          // A new word overrides the clear above, so back-to-back words have no bubble.
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= acc_dat | beat_word;
          m_axis_tkeep  <= acc_keep | beat_keep;
          m_axis_tlast  <= s_axis_tlast;
          acc_dat       <= '0;
          acc_keep      <= '0;
          lane          <= '0;
        end else begin
          acc_dat  <= acc_dat | beat_word;
          acc_keep <= acc_keep | beat_keep;
          lane     <= lane + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_upsizer.sv
// Directed bench for axis_upsizer (IN_WIDTH=32, RATIO=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled there or on the falling edge.
module tb_axis_upsizer;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic        m_axis_tvalid;
  logic [63:0] m_axis_tdata;
  logic [1:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  k;
    logic        l;
  } word_t;
  word_t q[$];

  always #5 aclk = ~aclk;

  axis_upsizer #(.IN_WIDTH(32), .RATIO(2)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  // Collect every word the downstream side accepts.
  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast});
  end

  // Stall monitor: outputs hold and input is refused while valid && !ready.
  logic        bp_mon = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_d;
  logic [1:0]  prev_k;
  logic        prev_l;
  always @(negedge aclk) begin
    if (bp_mon) begin
      if (prev_stall) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d || m_axis_tkeep !== prev_k || m_axis_tlast !== prev_l) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h k=%b l=%b, need v=1 d=%h k=%b l=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, prev_d, prev_k, prev_l);
        end
      end
      if (m_axis_tvalid && !m_axis_tready) begin
        checks++;
        if (s_axis_tready !== 1'b0) begin
          errors++;
          $display("FAIL stall_tready: s_axis_tready=%b, need 0", s_axis_tready);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_k = m_axis_tkeep;
      prev_l = m_axis_tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Presents one beat (caller is just after a rising edge) and returns just after the edge that accepts it.
  task automatic send(input logic [31:0] d, input logic l);
    logic acc;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      acc = s_axis_tready;
      @(posedge aclk);
      #1;
      if (acc) return;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: beat %h not accepted in 50 cycles", d);
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== 68'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h k=%b l=%b, need all 0", m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    end
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tready: got %b, need 0", s_axis_tready);
    end
    areset = 1'b0;
    #1;
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL release_tready: got %b, need 1", s_axis_tready);
    end
    @(posedge aclk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL release_tvalid: got %b, need 0", m_axis_tvalid);
    end
  endtask

  task automatic test_full_group();
    q.delete();
    m_axis_tready = 1'b1;
    send(32'h1111_1111, 1'b0);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL full_early_valid: got %b, need 0", m_axis_tvalid);
    end
    send(32'h2222_2222, 1'b1);
    s_axis_tvalid = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h2222_2222_1111_1111 || m_axis_tkeep !== 2'b11 || m_axis_tlast !== 1'b1) begin
      errors++;
      $display("FAIL full_word: got v=%b d=%h k=%b l=%b, need v=1 d=2222222211111111 k=11 l=1",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    end
    idle(1);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL full_valid_drop: got %b, need 0", m_axis_tvalid);
    end
    checks++;
    if (q.size() !== 1) begin
      errors++;
      $display("FAIL full_count: got %0d words, need 1", q.size());
    end
  endtask

  task automatic test_odd_packet();
    q.delete();
    m_axis_tready = 1'b1;
    send(32'hAAAA_0001, 1'b0);
    send(32'hBBBB_0002, 1'b0);
    send(32'hCCCC_0003, 1'b1);
    idle(3);
    checks++;
    if (q.size() !== 2) begin
      errors++;
      $display("FAIL odd_count: got %0d words, need 2", q.size());
    end else begin
      checks++;
      if (q[0].d !== 64'hBBBB_0002_AAAA_0001 || q[0].k !== 2'b11 || q[0].l !== 1'b0) begin
        errors++;
        $display("FAIL odd_word0: got d=%h k=%b l=%b, need d=bbbb0002aaaa0001 k=11 l=0", q[0].d, q[0].k, q[0].l);
      end
      checks++;
      if (q[1].d !== 64'h0000_0000_CCCC_0003 || q[1].k !== 2'b01 || q[1].l !== 1'b1) begin
        errors++;
        $display("FAIL odd_word1: got d=%h k=%b l=%b, need d=00000000cccc0003 k=01 l=1", q[1].d, q[1].k, q[1].l);
      end
    end
  endtask

  task automatic test_single_beat();
    q.delete();
    m_axis_tready = 1'b1;
    send(32'hDEAD_BEEF, 1'b1);
    idle(2);
    checks++;
    if (q.size() !== 1) begin
      errors++;
      $display("FAIL single_count: got %0d words, need 1", q.size());
    end else begin
      checks++;
      if (q[0].d !== 64'h0000_0000_DEAD_BEEF || q[0].k !== 2'b01 || q[0].l !== 1'b1) begin
        errors++;
        $display("FAIL single_word: got d=%h k=%b l=%b, need d=00000000deadbeef k=01 l=1", q[0].d, q[0].k, q[0].l);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] lo, hi;
    q.delete();
    m_axis_tready = 1'b0;
    bp_mon = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge aclk);
          #1;
          m_axis_tready = ~m_axis_tready;
        end
      end
      begin
        for (int i = 0; i < 8; i++) send(32'h1000_0000 + 32'(i), i == 7);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
    join
    m_axis_tready = 1'b1;
    idle(3);
    bp_mon = 1'b0;
    checks++;
    if (q.size() !== 4) begin
      errors++;
      $display("FAIL bp_count: got %0d words, need 4", q.size());
    end else begin
      for (int w = 0; w < 4; w++) begin
        lo = 32'h1000_0000 + 32'(2 * w);
        hi = lo + 32'd1;
        checks++;
        if (q[w].d !== {hi, lo} || q[w].k !== 2'b11 || q[w].l !== (w == 3)) begin
          errors++;
          $display("FAIL bp_word%0d: got d=%h k=%b l=%b, need d=%h k=11 l=%b", w, q[w].d, q[w].k, q[w].l, {hi, lo}, (w == 3));
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    q.delete();
    m_axis_tready = 1'b1;
    send(32'hBAD0_BAD0, 1'b0);
    s_axis_tvalid = 1'b0;
    areset = 1'b1;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_tready: got %b, need 0", s_axis_tready);
    end
    @(posedge aclk);
    #1;
    areset = 1'b0;
    send(32'hA5A5_0001, 1'b0);
    send(32'hA5A5_0002, 1'b1);
    idle(3);
    checks++;
    if (q.size() !== 1) begin
      errors++;
      $display("FAIL midrst_count: got %0d words, need 1", q.size());
    end else begin
      checks++;
      if (q[0].d !== 64'hA5A5_0002_A5A5_0001 || q[0].k !== 2'b11 || q[0].l !== 1'b1) begin
        errors++;
        $display("FAIL midrst_word: got d=%h k=%b l=%b, need d=a5a50002a5a50001 k=11 l=1", q[0].d, q[0].k, q[0].l);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_group();
    test_odd_packet();
    test_single_beat();
    test_backpressure();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
